// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM encoding and H accumulate helper.
// Used by the block sequencer and any stage that needs K or the IV.
package sha256_pkg;

    localparam int ROUNDS = 64;
    localparam int WORDS  = 16;

    localparam logic [31:0] H0_IV = 32'h6a09e667;
    localparam logic [31:0] H1_IV = 32'hbb67ae85;
    localparam logic [31:0] H2_IV = 32'h3c6ef372;
    localparam logic [31:0] H3_IV = 32'ha54ff53a;
    localparam logic [31:0] H4_IV = 32'h510e527f;
    localparam logic [31:0] H5_IV = 32'h9b05688c;
    localparam logic [31:0] H6_IV = 32'h1f83d9ab;
    localparam logic [31:0] H7_IV = 32'h5be0cd19;

    localparam logic [255:0] H_IV = {H0_IV, H1_IV, H2_IV, H3_IV,
                                     H4_IV, H5_IV, H6_IV, H7_IV};

    localparam logic [31:0] K [ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        INIT  = 3'd2,
        ROUND = 3'd3,
        ACCUM = 3'd4
    } state_t;

    // Per-word mod-2^32 add: carries stay inside each 32-bit lane.
    function automatic logic [255:0] h_fold(input logic [255:0] h, input logic [255:0] s);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i*32 +: 32] = h[i*32 +: 32] + s[i*32 +: 32];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// SHA-256 round-constant ROM, purely combinational (zero latency).
import sha256_pkg::*;

module sha256_k_rom (
    input  logic [5:0]  i_addr,
    output logic [31:0] o_k
);

    assign o_k = K[i_addr];

endmodule

// File: rtl/sha256_block_ctrl.sv
// SHA-256 block sequencer: buffers 16 words, drives 64 compressor rounds, folds result into H.
// Digest 67 cycles after word 15; WORD_READY low from INIT through ACCUM.
import sha256_pkg::*;

module sha256_block_ctrl (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  WORD_IN,
    input  logic         WORD_VALID,
    output logic         WORD_READY,
    input  logic         FIRST_BLOCK,
    output logic         CMP_INIT,
    output logic         CMP_EN,
    output logic [5:0]   CMP_I,
    output logic [31:0]  CMP_W,
    output logic [31:0]  CMP_K,
    output logic [255:0] H_OUT,
    input  logic [255:0] CMP_STATE,
    output logic [255:0] DIGEST,
    output logic         DIGEST_VALID
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [3:0]   r_wcnt;
    logic [5:0]   r_rcnt;
    logic [31:0]  r_buf [WORDS];
    logic [255:0] r_h;
    logic         r_word_rdy;
    logic         r_cmp_init;
    logic         r_cmp_en;
    logic         r_dig_vld;

    logic         w_word_rdy_nxt;
    logic         w_cmp_init_nxt;
    logic         w_cmp_en_nxt;
    logic         w_dig_vld_nxt;
    logic         w_acc;
    logic         w_last_word;
    logic [31:0]  w_k;

    assign w_acc       = WORD_VALID && r_word_rdy;
    assign w_last_word = w_acc && (r_wcnt == 4'(WORDS - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_acc) w_state_nxt = LOAD;
            LOAD:    if (w_last_word) w_state_nxt = INIT;
            INIT:    w_state_nxt = ROUND;
            ROUND:   if (r_rcnt == 6'(ROUNDS - 1)) w_state_nxt = ACCUM;
            ACCUM:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with r_state.
    always_comb begin
        w_word_rdy_nxt = (w_state_nxt == IDLE) || (w_state_nxt == LOAD);
        w_cmp_init_nxt = (w_state_nxt == INIT);
        w_cmp_en_nxt   = (w_state_nxt == ROUND);
        w_dig_vld_nxt  = (r_state == ACCUM);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_word_rdy <= 1'b1;
            r_cmp_init <= 1'b0;
            r_cmp_en   <= 1'b0;
            r_dig_vld  <= 1'b0;
        end else begin
            r_word_rdy <= w_word_rdy_nxt;
            r_cmp_init <= w_cmp_init_nxt;
            r_cmp_en   <= w_cmp_en_nxt;
            r_dig_vld  <= w_dig_vld_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wcnt <= '0;
            r_rcnt <= '0;
            r_h    <= H_IV;
            for (int i = 0; i < WORDS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            if (w_acc) begin
                r_buf[r_wcnt] <= WORD_IN;
                r_wcnt        <= r_wcnt + 4'd1;
            end
            // rcnt wraps to 0 after round 63, so CMP_I idles at 0.
            if (r_state == ROUND) begin
                r_rcnt <= r_rcnt + 6'd1;
            end
            if (w_acc && (r_wcnt == 4'd0) && FIRST_BLOCK) begin
                r_h <= H_IV;
            end else if (r_state == ACCUM) begin
                r_h <= h_fold(r_h, CMP_STATE);
            end
        end
    end

    sha256_k_rom u_k_rom (
        .i_addr (r_rcnt),
        .o_k    (w_k)
    );

    assign WORD_READY   = r_word_rdy;
    assign CMP_INIT     = r_cmp_init;
    assign CMP_EN       = r_cmp_en;
    assign CMP_I        = r_rcnt;
    assign CMP_K        = r_cmp_en ? w_k : 32'd0;
    assign CMP_W        = (r_cmp_en && (r_rcnt < 6'(WORDS))) ? r_buf[r_rcnt[3:0]] : 32'd0;
    assign H_OUT        = r_h;
    assign DIGEST       = r_h;
    assign DIGEST_VALID = r_dig_vld;

endmodule

// File: doc/sha256_block_ctrl.md
Name: sha256_block_ctrl

Overview:
Block sequencer directly upstream of the message-schedule/compression stage. Accepts a padded 512-bit message block as 16 big-endian 32-bit words over a valid/ready handshake. Drives the compressor for 64 rounds, with round index, message word and round constant, then folds the compressor's final working variables into the running hash H0..H7. Publishes the 256-bit digest after every block; multi-block messages chain H automatically.

Parameters:
ROUNDS, 64, compression rounds per block; fixed by SHA-256 and not overridden.
WORDS, 16, message words per block.

Ports:
CLK  in  1  clock, all state on rising edge
RESET  in  1  asynchronous, active-high; clears all state
WORD_IN  in  32  message word, big-endian, word 0 first
WORD_VALID  in  1  WORD_IN valid
WORD_READY  out  1  block accepts a word this cycle
FIRST_BLOCK  in  1  sampled with word 0 of a block; 1 = reload H from IV before this block
CMP_INIT  out  1  one-cycle pulse; compressor loads a..h from H_OUT
CMP_EN  out  1  high for exactly 64 cycles, one round per cycle
CMP_I  out  6  round index 0..63, valid while CMP_EN=1
CMP_W  out  32  message word; buffer word CMP_I for CMP_I<16, else 0 (compressor extends internally)
CMP_K  out  32  round constant K[CMP_I]
H_OUT  out  256  current H0..H7, H0 in [255:224]
CMP_STATE  in  256  compressor a..h after round 63, a in [255:224]
DIGEST  out  256  equals H_OUT; meaningful when DIGEST_VALID=1
DIGEST_VALID  out  1  one-cycle pulse per completed block

Behaviour:
- Reset values: state IDLE; word counter 0; round counter 0; H0..H7 = SHA-256 IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19). WORD_READY=1. CMP_INIT, CMP_EN and DIGEST_VALID are 0. CMP_I, CMP_W and CMP_K are 0.
- FSM: IDLE -> LOAD -> INIT -> ROUND -> ACCUM -> IDLE.
- IDLE/LOAD: WORD_READY=1. A word is accepted on a cycle where WORD_VALID and WORD_READY are both 1. It is stored at buffer[cnt], and cnt increments.
- On acceptance of word 0, FIRST_BLOCK is latched. If it is 1, H is reloaded with the IV on that same edge.
- WORD_VALID gaps are allowed; the block simply waits.
- On acceptance of word 15: go to INIT and drop WORD_READY.
- WORD_READY stays 0 from INIT through ACCUM. WORD_VALID is ignored there; no word is lost or stored.
- INIT: 1 cycle, CMP_INIT=1. Then ROUND with rcnt=0.
- ROUND: CMP_EN=1, CMP_I=rcnt, CMP_K=ROM[rcnt], CMP_W=buffer[rcnt] if rcnt<16 else 0. rcnt increments every cycle. After the rcnt=63 cycle, go to ACCUM.
- ACCUM: 1 cycle. Each Hi <= Hi + CMP_STATE word i, mod 2^32 per word; carries never propagate between words.
- DIGEST_VALID=1 for the first cycle back in IDLE, when DIGEST shows the updated H. H is held until the next block's accumulate or IV reload.
- Latency: word 15 accepted at edge N. CMP_INIT is high in cycle N+1, rounds run in cycles N+2..N+65, ACCUM is cycle N+66, and DIGEST_VALID is high in cycle N+67.
- Back-to-back: WORD_READY=1 in the DIGEST_VALID cycle, so the next block's word 0 may be accepted in that same cycle.
- FIRST_BLOCK=0 on a block continues from the current H, i.e. chaining.
- Reset mid-operation, any state: immediate return to the reset values. The partial block is discarded and H returns to the IV. There is no DIGEST_VALID for the aborted block.
- K ROM: the 64 standard SHA-256 constants, K[0]=428a2f98, K[1]=71374491, ..., K[63]=c67178f2. It is combinational, indexed by rcnt.
- Outputs are registered except CMP_K, CMP_W and DIGEST/H_OUT, which are combinational decodes of registers.

Decomposition:
- Shared package sha256_pkg holds: IV constants H0_IV..H7_IV; the K constant array; the FSM state encoding (IDLE, LOAD, INIT, ROUND, ACCUM); ROUNDS=64 and WORDS=16.
- One sub-module, sha256_k_rom: 6-bit address in, 32-bit constant out, combinational. It is reused by any other stage needing K.

Test Plan:
- "abc", single padded block (61626380 0000...0000 00000018), FIRST_BLOCK=1, bench includes the compressor. Required: DIGEST=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, and DIGEST_VALID exactly 67 cycles after word 15 is accepted.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 with FIRST_BLOCK=1, block 2 with FIRST_BLOCK=0, block 2 presented back-to-back. Required: final DIGEST=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, and two DIGEST_VALID pulses.
- Random WORD_VALID gaps while loading "abc" -> same digest. WORD_VALID held high during ROUND -> WORD_READY=0 and the buffer unchanged.
- Monitor the compressor port during "abc". Required:
  - CMP_INIT is a single pulse;
  - CMP_I steps 0..63 contiguously;
  - CMP_K=428a2f98 at I=0 and c67178f2 at I=63;
  - CMP_W=61626380 at I=0, 00000018 at I=15, and 0 for I>=16.
- Assert RESET at round 30, release it, then send "abc" -> no DIGEST_VALID for the aborted block, H_OUT=IV right after reset, and the correct "abc" digest afterwards.
- Second "abc" block sent with FIRST_BLOCK=1 after a completed block -> identical digest, proving the IV reload.
